// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue feeding the data cache.
// Ops enter at the tail from dispatch, pick up missing base/store-data
// operands from the CDB while they wait, and leave from the head once
// the head's operands are complete and the cache accepts it.
module ls_issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int TAG_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Disp_En,
    input  logic             Disp_Opcode,
    input  logic [TAG_W-1:0] Disp_Tag,
    input  logic [15:0]      Disp_Imm,
    input  logic [31:0]      Disp_RsData,
    input  logic [TAG_W-1:0] Disp_RsTag,
    input  logic             Disp_RsValid,
    input  logic [31:0]      Disp_RtData,
    input  logic [TAG_W-1:0] Disp_RtTag,
    input  logic             Disp_RtValid,
    input  logic             Cdb_Valid,
    input  logic [TAG_W-1:0] Cdb_Tag,
    input  logic [31:0]      Cdb_Data,
    output logic             Full,
    output logic [31:0]      IssueQue_Data,
    output logic [31:0]      IssueQue_Address,
    output logic [TAG_W-1:0] IssueQue_Tag,
    output logic             IssueQue_Opcode,
    output logic             IssueQue_Ready,
    input  logic             IssueQue_Issue
);

    typedef struct packed {
        logic             opcode;   // 1 = load, 0 = store
        logic [TAG_W-1:0] tag;
        logic [15:0]      imm;
        logic [31:0]      rs_data;
        logic [TAG_W-1:0] rs_tag;
        logic             rs_valid;
        logic [31:0]      rt_data;
        logic [TAG_W-1:0] rt_tag;
        logic             rt_valid;
    } entry_t;

    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    entry_t head_e;
    entry_t disp_e;
    logic   head_valid;
    logic   push;
    logic   pop;

    assign head_e     = entry_q[head_q];
    assign head_valid = valid_q[head_q];

    // A same-cycle pop never frees a slot for dispatch: Full is purely registered.
    assign Full = (count_q == COUNT_FULL);
    assign push = Disp_En && !Full;

    // Ready is built only from head registers so the cache may form Issue from it.
    assign IssueQue_Ready   = head_valid && head_e.rs_valid && (head_e.opcode || head_e.rt_valid);
    assign IssueQue_Address = head_valid ? head_e.rs_data + {{16{head_e.imm[15]}}, head_e.imm} : '0;
    assign IssueQue_Data    = (head_valid && !head_e.opcode) ? head_e.rt_data : '0;
    assign IssueQue_Tag     = head_valid ? head_e.tag : '0;
    assign IssueQue_Opcode  = head_valid && head_e.opcode;
    assign pop              = IssueQue_Issue && IssueQue_Ready;

    // Build the incoming entry, forwarding a same-cycle CDB result into pending operands.
    always_comb begin
        // NOTE: every field gets a value on every path, so no latch is inferred.
        disp_e          = '0;
        disp_e.opcode   = Disp_Opcode;
        disp_e.tag      = Disp_Tag;
        disp_e.imm      = Disp_Imm;
        disp_e.rs_tag   = Disp_RsTag;
        disp_e.rt_tag   = Disp_RtTag;
        disp_e.rs_data  = Disp_RsData;
        disp_e.rs_valid = Disp_RsValid;
        disp_e.rt_data  = Disp_RtData;
        disp_e.rt_valid = Disp_RtValid;
        if (!Disp_RsValid && Cdb_Valid && (Cdb_Tag == Disp_RsTag)) begin
            disp_e.rs_data  = Cdb_Data;
            disp_e.rs_valid = 1'b1;
        end
        if (!Disp_RtValid && Cdb_Valid && (Cdb_Tag == Disp_RtTag)) begin
            disp_e.rt_data  = Cdb_Data;
            disp_e.rt_valid = 1'b1;
        end
    end

    // Next-state of the queue: CDB snoop, then push at tail and pop at head.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && Cdb_Valid) begin
                if (!entry_q[i].rs_valid && (entry_q[i].rs_tag == Cdb_Tag)) begin
                    entry_d[i].rs_data  = Cdb_Data;
                    entry_d[i].rs_valid = 1'b1;
                end
                if (!entry_q[i].rt_valid && (entry_q[i].rt_tag == Cdb_Tag)) begin
                    entry_d[i].rt_data  = Cdb_Data;
                    entry_d[i].rt_valid = 1'b1;
                end
            end
        end

        if (push) begin
            entry_d[tail_q] = disp_e;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: valids and pointers, cleared asynchronously.
    always_ff @(posedge Clk or posedge Rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage.
    always_ff @(posedge Clk) begin
        // NOTE: payload is not reset; the valid bits gate every use of it.
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_ls_issue_queue.sv
// Self-checking bench for ls_issue_queue: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_ls_issue_queue;

    logic        clk;
    logic        rst;
    logic        disp_en;
    logic        disp_opcode;
    logic [4:0]  disp_tag;
    logic [15:0] disp_imm;
    logic [31:0] disp_rs_data;
    logic [4:0]  disp_rs_tag;
    logic        disp_rs_valid;
    logic [31:0] disp_rt_data;
    logic [4:0]  disp_rt_tag;
    logic        disp_rt_valid;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        full;
    logic [31:0] iq_data;
    logic [31:0] iq_addr;
    logic [4:0]  iq_tag;
    logic        iq_opcode;
    logic        iq_ready;
    logic        iq_issue;

    int checks = 0;
    int passes = 0;

    ls_issue_queue #(.DEPTH(4), .PTR_W(2), .TAG_W(5)) dut (
        .Clk              (clk),
        .Rst              (rst),
        .Disp_En          (disp_en),
        .Disp_Opcode      (disp_opcode),
        .Disp_Tag         (disp_tag),
        .Disp_Imm         (disp_imm),
        .Disp_RsData      (disp_rs_data),
        .Disp_RsTag       (disp_rs_tag),
        .Disp_RsValid     (disp_rs_valid),
        .Disp_RtData      (disp_rt_data),
        .Disp_RtTag       (disp_rt_tag),
        .Disp_RtValid     (disp_rt_valid),
        .Cdb_Valid        (cdb_valid),
        .Cdb_Tag          (cdb_tag),
        .Cdb_Data         (cdb_data),
        .Full             (full),
        .IssueQue_Data    (iq_data),
        .IssueQue_Address (iq_addr),
        .IssueQue_Tag     (iq_tag),
        .IssueQue_Opcode  (iq_opcode),
        .IssueQue_Ready   (iq_ready),
        .IssueQue_Issue   (iq_issue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-ordered list of waiting ops.
    typedef struct {
        bit          ld;
        logic [4:0]  tag;
        logic [15:0] imm;
        bit          rs_ok;
        logic [31:0] rs;
        logic [4:0]  rs_tag;
        bit          rt_ok;
        logic [31:0] rt;
        logic [4:0]  rt_tag;
    } op_t;

    op_t mq[$];

    function automatic bit op_ready(op_t o);
        return o.rs_ok && (o.ld || o.rt_ok);
    endfunction

    task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit  do_pop;
        bit  was_full;
        op_t n;
        if (rst) begin
            mq.delete();
            return;
        end
        do_pop   = iq_issue && (mq.size() > 0) && op_ready(mq[0]);
        was_full = (mq.size() == 4);
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].rs_ok && mq[i].rs_tag == cdb_tag) begin
                    mq[i].rs_ok = 1'b1;
                    mq[i].rs    = cdb_data;
                end
                if (!mq[i].rt_ok && mq[i].rt_tag == cdb_tag) begin
                    mq[i].rt_ok = 1'b1;
                    mq[i].rt    = cdb_data;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (disp_en && !was_full) begin
            n.ld     = disp_opcode;
            n.tag    = disp_tag;
            n.imm    = disp_imm;
            n.rs_tag = disp_rs_tag;
            n.rt_tag = disp_rt_tag;
            n.rs_ok  = disp_rs_valid || (cdb_valid && cdb_tag == disp_rs_tag);
            n.rs     = disp_rs_valid ? disp_rs_data : (n.rs_ok ? cdb_data : disp_rs_data);
            n.rt_ok  = disp_rt_valid || (cdb_valid && cdb_tag == disp_rt_tag);
            n.rt     = disp_rt_valid ? disp_rt_data : (n.rt_ok ? cdb_data : disp_rt_data);
            mq.push_back(n);
        end
    endtask

    task automatic check_outputs(string t);
        if (mq.size() == 0) begin
            check({t, ":full"},   full,      32'd0);
            check({t, ":ready"},  iq_ready,  32'd0);
            check({t, ":addr"},   iq_addr,   32'd0);
            check({t, ":data"},   iq_data,   32'd0);
            check({t, ":tag"},    iq_tag,    32'd0);
            check({t, ":opcode"}, iq_opcode, 32'd0);
        end else begin
            op_t         h;
            logic [31:0] exp_addr;
            h        = mq[0];
            exp_addr = h.rs + {{16{h.imm[15]}}, h.imm};
            check({t, ":full"},   full,      32'(mq.size() == 4));
            check({t, ":ready"},  iq_ready,  32'(op_ready(h)));
            check({t, ":tag"},    iq_tag,    32'(h.tag));
            check({t, ":opcode"}, iq_opcode, 32'(h.ld));
            if (op_ready(h)) begin
                check({t, ":addr"}, iq_addr, exp_addr);
                check({t, ":data"}, iq_data, h.ld ? 32'd0 : h.rt);
            end
        end
    endtask

    task automatic set_idle();
        disp_en       = 1'b0;
        disp_opcode   = 1'b0;
        disp_tag      = '0;
        disp_imm      = '0;
        disp_rs_data  = '0;
        disp_rs_tag   = '0;
        disp_rs_valid = 1'b0;
        disp_rt_data  = '0;
        disp_rt_tag   = '0;
        disp_rt_valid = 1'b0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_data      = '0;
        iq_issue      = 1'b0;
    endtask

    task automatic set_disp(bit ld, logic [4:0] tag, logic [15:0] imm,
                            logic [31:0] rs, logic [4:0] rs_tag, bit rs_v,
                            logic [31:0] rt, logic [4:0] rt_tag, bit rt_v);
        disp_en       = 1'b1;
        disp_opcode   = ld;
        disp_tag      = tag;
        disp_imm      = imm;
        disp_rs_data  = rs;
        disp_rs_tag   = rs_tag;
        disp_rs_valid = rs_v;
        disp_rt_data  = rt;
        disp_rt_tag   = rt_tag;
        disp_rt_valid = rt_v;
    endtask

    task automatic set_cdb(logic [4:0] tag, logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // One clock: edge, model update, sample at the falling edge, clear inputs.
    task automatic tick(string t);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(t);
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // T1: ready load issues one cycle after dispatch.
        set_disp(1, 5'd3, 16'd4, 32'h10, 5'd0, 1, 32'h0, 5'd0, 0);
        tick("t1_disp");
        check("t1_ready", iq_ready, 32'd1);
        check("t1_addr", iq_addr, 32'h14);
        check("t1_opcode", iq_opcode, 32'd1);
        iq_issue = 1'b1;
        tick("t1_pop");
        check("t1_empty_ready", iq_ready, 32'd0);

        // T2: store waits for data, woken by CDB.
        set_disp(0, 5'd5, 16'hFFFC, 32'h8, 5'd0, 1, 32'h0, 5'd9, 0);
        tick("t2_disp");
        check("t2_wait_ready", iq_ready, 32'd0);
        set_cdb(5'd9, 32'hAB);
        tick("t2_cdb");
        check("t2_ready", iq_ready, 32'd1);
        check("t2_addr", iq_addr, 32'h4);
        check("t2_data", iq_data, 32'hAB);
        iq_issue = 1'b1;
        tick("t2_pop");

        // T3: a ready younger op waits behind a blocked head.
        set_disp(1, 5'd10, 16'd0, 32'h0, 5'd7, 0, 32'h0, 5'd0, 0);
        tick("t3_disp_a");
        set_disp(1, 5'd11, 16'd8, 32'h200, 5'd0, 1, 32'h0, 5'd0, 0);
        iq_issue = 1'b1;
        tick("t3_disp_b");
        check("t3_blocked", iq_ready, 32'd0);
        set_cdb(5'd7, 32'h100);
        tick("t3_cdb");
        check("t3_head_a", iq_tag, 32'd10);
        iq_issue = 1'b1;
        tick("t3_pop_a");
        check("t3_head_b", iq_tag, 32'd11);
        iq_issue = 1'b1;
        tick("t3_pop_b");

        // T4: fill, drop when full (even with a same-cycle pop), drain in order.
        for (int k = 0; k < 4; k++) begin
            set_disp(1, 5'(20 + k), 16'(k), 32'h1000, 5'd0, 1, 32'h0, 5'd0, 0);
            tick("t4_fill");
        end
        check("t4_full", full, 32'd1);
        set_disp(1, 5'd24, 16'd0, 32'h0, 5'd0, 1, 32'h0, 5'd0, 0);
        tick("t4_drop");
        check("t4_head_kept", iq_tag, 32'd20);
        set_disp(1, 5'd25, 16'd0, 32'h0, 5'd0, 1, 32'h0, 5'd0, 0);
        iq_issue = 1'b1;
        tick("t4_drop_pop");
        check("t4_unfull", full, 32'd0);
        for (int k = 1; k < 4; k++) begin
            check("t4_order", iq_tag, 32'(20 + k));
            iq_issue = 1'b1;
            tick("t4_drain");
        end
        check("t4_drained", iq_ready, 32'd0);

        // T5: dispatch-cycle CDB forwarding.
        set_disp(1, 5'd12, 16'd0, 32'h0, 5'd2, 0, 32'h0, 5'd0, 0);
        set_cdb(5'd2, 32'h20);
        tick("t5_fwd");
        check("t5_ready", iq_ready, 32'd1);
        check("t5_addr", iq_addr, 32'h20);
        iq_issue = 1'b1;
        tick("t5_pop");

        // T6: asynchronous reset with ready entries queued.
        for (int k = 0; k < 3; k++) begin
            set_disp(1, 5'(13 + k), 16'd0, 32'h40, 5'd0, 1, 32'h0, 5'd0, 0);
            tick("t6_fill");
        end
        check("t6_pre_ready", iq_ready, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_ready", iq_ready, 32'd0);
        check("t6_async_full", full, 32'd0);
        check("t6_async_addr", iq_addr, 32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        check_outputs("t6_post");
        set_disp(1, 5'd30, 16'd1, 32'h50, 5'd0, 1, 32'h0, 5'd0, 0);
        tick("t6_fresh");
        check("t6_fresh_tag", iq_tag, 32'd30);
        check("t6_fresh_addr", iq_addr, 32'h51);
        iq_issue = 1'b1;
        tick("t6_pop");

        // Randomized traffic with a small tag space so CDB hits are frequent.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1)
                set_disp($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 16'($urandom),
                         $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                         $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                set_cdb(5'($urandom_range(0, 7)), $urandom);
            iq_issue = ($urandom_range(0, 9) < 6);
            tick("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
